// File: rtl/irq_controller.sv
// irq_controller: edge-latched, masked, fixed-priority interrupt controller on the CPU data bus.
// Latency: request edge -> pend after 2 edges, INT one edge later; bus reads are combinational.
// Backpressure: none; every bus access completes in one cycle, the claim/EOI handshake gates INT.
module irq_controller #(
   parameter int          NUM_SRC   = 8,
   parameter logic [31:0] BASE_ADDR = 32'hFFFF_FF00
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_SRC-1:0] irq_src,
   input  logic [31:0]        addr,
   input  logic [31:0]        wdata,
   input  logic               mem_w,
   output logic               sel,
   output logic [31:0]        rdata,
   output logic               INT
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ASSERT  = 2'd1,
      SERVICE = 2'd2
   } stateT;

   // Word offsets inside the register window.
   localparam logic [5:0] OFF_PEND   = 6'h00;
   localparam logic [5:0] OFF_MASK   = 6'h01;
   localparam logic [5:0] OFF_CLAIM  = 6'h02;
   localparam logic [5:0] OFF_EOI    = 6'h03;
   localparam logic [5:0] OFF_STATUS = 6'h04;

   logic [NUM_SRC-1:0] syncS1, syncS2, syncS3;
   logic [NUM_SRC-1:0] rise;
   logic [NUM_SRC-1:0] pend, pendNext;
   logic [NUM_SRC-1:0] mask;
   logic [NUM_SRC-1:0] pendMasked;
   logic [NUM_SRC-1:0] w1cBits, claimClr;
   logic               anyMasked;
   logic [4:0]         winnerId;
   logic [4:0]         claimId;
   logic [5:0]         wordOff;
   logic               regWr, wrPend, wrMask, wrClaim, wrEoi;
   logic               claimTake;
   logic               intNext;
   stateT              state, stateNext;
   logic               unusedBits;

   // Byte lanes and data bits above the source count carry no meaning here.
   assign unusedBits = ^{addr[1:0], wdata};

   // Bus decode: window hit and per-register write strobes.
   assign sel     = (addr[31:8] == BASE_ADDR[31:8]);
   assign wordOff = addr[7:2];
   assign regWr   = sel & mem_w;
   assign wrPend  = regWr & (wordOff == OFF_PEND);
   assign wrMask  = regWr & (wordOff == OFF_MASK);
   assign wrClaim = regWr & (wordOff == OFF_CLAIM);
   assign wrEoi   = regWr & (wordOff == OFF_EOI);

   assign rise       = syncS2 & ~syncS3;
   assign pendMasked = pend & mask;
   assign anyMasked  = |pendMasked;

   // Fixed priority: the lowest-numbered enabled pending source wins.
   always_comb begin
      winnerId = 5'd0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (pendMasked[i]) winnerId = 5'(i);
      end
   end

   // Pending update: a fresh edge always survives a same-cycle W1C or claim clear.
   always_comb begin
      w1cBits  = wrPend ? wdata[NUM_SRC-1:0] : '0;
      claimClr = (claimTake && anyMasked) ? (NUM_SRC'(1) << winnerId) : '0;
      pendNext = (pend & ~w1cBits & ~claimClr) | rise;
   end

   // Next-state and INT decode; INT is high exactly while waiting for a claim.
   always_comb begin
      stateNext = state;
      claimTake = 1'b0;
      case (state)
         IDLE: begin
            if (anyMasked) stateNext = ASSERT;
         end
         ASSERT: begin
            if (wrClaim) begin
               claimTake = 1'b1;
               stateNext = SERVICE;
            end else if (!anyMasked) begin
               stateNext = IDLE;
            end
         end
         SERVICE: begin
            if (wrEoi) stateNext = IDLE;
         end
         default: stateNext = IDLE;
      endcase
      intNext = (stateNext == ASSERT);
   end

   // Three-flop synchroniser per request line.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         syncS1 <= '0;
         syncS2 <= '0;
         syncS3 <= '0;
      end else begin
         syncS1 <= irq_src;
         syncS2 <= syncS1;
         syncS3 <= syncS2;
      end
   end

   // Pending and mask registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pend <= '0;
         mask <= '0;
      end else begin
         pend <= pendNext;
         if (wrMask) mask <= wdata[NUM_SRC-1:0];
      end
   end

   // State, registered INT and the id captured at claim time.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         INT     <= 1'b0;
         claimId <= 5'd0;
      end else begin
         state <= stateNext;
         INT   <= intNext;
         if (claimTake) claimId <= winnerId;
      end
   end

   // Side-effect-free read mux; anything unmapped or out of window reads zero.
   always_comb begin
      rdata = 32'd0;
      if (sel) begin
         case (wordOff)
            OFF_PEND:   rdata = 32'(pend);
            OFF_MASK:   rdata = 32'(mask);
            OFF_CLAIM:  rdata = {(state == SERVICE), 26'd0, claimId};
            OFF_EOI:    rdata = 32'd0;
            OFF_STATUS: rdata = {28'd0, INT, anyMasked, 2'(state)};
            default:    rdata = 32'd0;
         endcase
      end
   end

endmodule

// File: tb/tb_irq_controller.sv
// Randomised scoreboard bench for irq_controller against a cycle-level reference model.
// Each driven cycle pushes the predicted {INT, sel, rdata}; a monitor pops and compares at negedge.
// The model tracks sampled request history as a queue and applies register rules arithmetically.
module tb_irq_controller;

   localparam int          NS   = 8;
   localparam logic [31:0] BASE = 32'hFFFF_FF00;

   logic          clk = 1'b0;
   logic          reset;
   logic [NS-1:0] irqSrc;
   logic [31:0]   addr, wdata, rdata;
   logic          memW, sel, intOut;

   always #5 clk = ~clk;

   irq_controller #(.NUM_SRC(NS), .BASE_ADDR(BASE)) dut (
      .clk(clk), .reset(reset), .irq_src(irqSrc), .addr(addr), .wdata(wdata),
      .mem_w(memW), .sel(sel), .rdata(rdata), .INT(intOut)
   );

   typedef struct packed {
      logic        i;
      logic        s;
      logic [31:0] d;
   } expT;

   expT expQ[$];
   int  vectors     = 0;
   int  miscompares = 0;

   // Reference model state.
   logic [NS-1:0] mPend, mMask;
   logic [4:0]    mId;
   int            mState;     // 0 idle, 1 waiting for claim, 2 in service
   logic          mInt;
   logic [NS-1:0] hist[$];    // request samples at the last three edges, oldest first
   logic [NS-1:0] irqCur;

   task automatic modelReset();
      mPend  = '0;
      mMask  = '0;
      mId    = 5'd0;
      mState = 0;
      mInt   = 1'b0;
      hist.delete();
      repeat (3) hist.push_back('0);
   endtask

   // One clock edge of the model, using the inputs present at that edge.
   task automatic modelEdge();
      logic [NS-1:0] pm, riseV, clr;
      int  win, off, nxt;
      bit  wr;
      pm  = mPend & mMask;
      win = -1;
      for (int i = 0; i < NS; i++) if (pm[i] && win < 0) win = i;
      // A line first seen high two edges ago and low the edge before that sets pend now.
      riseV = hist[1] & ~hist[0];
      wr    = memW && ((addr >> 8) == (BASE >> 8));
      off   = int'(addr[7:0]);
      clr   = '0;
      if (wr && off == 0) clr = wdata[NS-1:0];
      nxt = mState;
      if (mState == 0 && pm != 0) nxt = 1;
      else if (mState == 1 && wr && off == 8) begin
         nxt = 2;
         if (win >= 0) begin
            mId      = win[4:0];
            clr[win] = 1'b1;
         end else mId = 5'd0;
      end
      else if (mState == 1 && pm == 0) nxt = 0;
      else if (mState == 2 && wr && off == 12) nxt = 0;
      mPend = (mPend & ~clr) | riseV;
      if (wr && off == 4) mMask = wdata[NS-1:0];
      mState = nxt;
      mInt   = (nxt == 1);
      void'(hist.pop_front());
      hist.push_back(irqSrc);
   endtask

   function automatic expT predict();
      expT e;
      int  off;
      e.i = mInt;
      e.s = ((addr >> 8) == (BASE >> 8));
      e.d = 32'd0;
      off = int'(addr[7:0]);
      if (e.s) begin
         case (off)
            0:  e.d = 32'(mPend);
            4:  e.d = 32'(mMask);
            8:  e.d = {(mState == 2), 26'd0, mId};
            16: e.d = {28'd0, mInt, ((mPend & mMask) != 0), mState[1:0]};
            default: e.d = 32'd0;
         endcase
      end
      return e;
   endfunction

   // Advance one cycle: model the edge, drive new inputs, predict the outputs.
   task automatic step(input logic rstN, input logic [31:0] a, input logic [31:0] w, input logic mw);
      @(posedge clk);
      if (reset) modelEdge();
      #1;
      reset  = rstN;
      irqSrc = irqCur;
      addr   = a;
      wdata  = w;
      memW   = mw;
      if (!rstN) modelReset();
      expQ.push_back(predict());
   endtask

   task automatic wrReg(input logic [7:0] off, input logic [31:0] d);
      step(1'b1, BASE | 32'(off), d, 1'b1);
   endtask

   task automatic rdReg(input logic [7:0] off);
      step(1'b1, BASE | 32'(off), 32'd0, 1'b0);
   endtask

   // Monitor: compares every presented cycle against the oldest prediction.
   initial begin
      expT e;
      forever begin
         @(negedge clk);
         if (expQ.size() != 0) begin
            e = expQ.pop_front();
            vectors++;
            if ({intOut, sel, rdata} !== e) begin
               miscompares++;
               $display("FAIL outputs t=%0t addr=%h: got INT=%b sel=%b rdata=%h, want INT=%b sel=%b rdata=%h",
                        $time, addr, intOut, sel, rdata, e.i, e.s, e.d);
            end
         end
      end
   end

   initial begin
      logic [7:0] offTab [6];
      offTab[0] = 8'h00; offTab[1] = 8'h04; offTab[2] = 8'h08;
      offTab[3] = 8'h0C; offTab[4] = 8'h10; offTab[5] = 8'h20;

      reset  = 1'b0;
      irqSrc = '0;
      irqCur = '0;
      addr   = BASE;
      wdata  = 32'd0;
      memW   = 1'b0;
      modelReset();

      // Reset state.
      step(1'b0, BASE | 32'h10, 32'd0, 1'b0);
      step(1'b0, BASE | 32'h04, 32'd0, 1'b0);
      rdReg(8'h00);
      rdReg(8'h08);

      // Single source, claim and EOI.
      wrReg(8'h04, 32'h01);
      irqCur = 8'h01;
      repeat (3) rdReg(8'h00);
      irqCur = 8'h00;
      rdReg(8'h10);
      rdReg(8'h10);
      wrReg(8'h08, 32'h0);
      rdReg(8'h08);
      wrReg(8'h0C, 32'h0);
      rdReg(8'h10);

      // Two sources together: priority, then the second after EOI.
      wrReg(8'h04, 32'hFF);
      irqCur = 8'h24;
      repeat (2) rdReg(8'h10);
      irqCur = 8'h00;
      repeat (3) rdReg(8'h10);
      wrReg(8'h08, 32'h0);
      rdReg(8'h08);
      rdReg(8'h00);
      wrReg(8'h0C, 32'h0);
      rdReg(8'h10);
      rdReg(8'h10);
      wrReg(8'h08, 32'h0);
      rdReg(8'h08);
      wrReg(8'h0C, 32'h0);

      // Masked request, then unmask.
      wrReg(8'h04, 32'h00);
      irqCur = 8'h08;
      repeat (2) rdReg(8'h00);
      irqCur = 8'h00;
      repeat (3) rdReg(8'h00);
      wrReg(8'h04, 32'h08);
      repeat (2) rdReg(8'h10);
      wrReg(8'h00, 32'h08);
      repeat (2) rdReg(8'h10);

      // W1C drops ASSERT; then a new edge lands in the same cycle as a W1C.
      wrReg(8'h04, 32'h02);
      irqCur = 8'h02;
      rdReg(8'h10);
      irqCur = 8'h00;
      repeat (3) rdReg(8'h10);
      wrReg(8'h00, 32'h02);
      repeat (2) rdReg(8'h10);
      irqCur = 8'h02;
      rdReg(8'h10);
      irqCur = 8'h00;
      rdReg(8'h10);
      rdReg(8'h10);
      irqCur = 8'h02;
      rdReg(8'h10);
      irqCur = 8'h00;
      rdReg(8'h10);
      wrReg(8'h00, 32'h02);
      rdReg(8'h00);
      rdReg(8'h10);
      wrReg(8'h00, 32'hFF);
      repeat (2) rdReg(8'h10);

      // In service, a new request only accumulates; then reset mid-service.
      wrReg(8'h04, 32'h01);
      irqCur = 8'h01;
      rdReg(8'h10);
      irqCur = 8'h00;
      repeat (3) rdReg(8'h10);
      wrReg(8'h08, 32'h0);
      irqCur = 8'h01;
      rdReg(8'h10);
      irqCur = 8'h00;
      repeat (3) rdReg(8'h00);
      rdReg(8'h10);
      step(1'b0, BASE | 32'h00, 32'd0, 1'b0);
      step(1'b0, BASE | 32'h04, 32'd0, 1'b0);
      rdReg(8'h04);

      // Out-of-window write and unmapped in-window read.
      wrReg(8'h04, 32'h5A);
      step(1'b1, 32'h0000_0004, 32'hFF, 1'b1);
      rdReg(8'h04);
      rdReg(8'h20);
      wrReg(8'h20, 32'hFFFF_FFFF);
      rdReg(8'h20);

      // Randomised traffic.
      for (int n = 0; n < 4000; n++) begin
         int          r;
         logic [31:0] a, w;
         logic        mw, rs;
         for (int b = 0; b < NS; b++) if ($urandom_range(5) == 0) irqCur[b] = ~irqCur[b];
         r  = $urandom_range(99);
         rs = 1'b1;
         mw = 1'b0;
         w  = $urandom;
         a  = BASE | 32'(offTab[$urandom_range(5)]);
         if (r < 2) rs = 1'b0;
         else if (r < 8) begin
            a  = $urandom & 32'hFFFF_FFFC;
            if ((a >> 8) == (BASE >> 8)) a = 32'h0000_0004;
            mw = 1'($urandom_range(1));
         end
         else if (r < 50) mw = 1'b0;
         else begin
            mw = 1'b1;
            if (r < 62)      a = BASE | 32'h08;
            else if (r < 72) a = BASE | 32'h0C;
            else if (r < 82) a = BASE | 32'h04;
            else if (r < 90) begin
               a = BASE | 32'h00;
               w = $urandom & $urandom;
            end
         end
         step(rs, a, w, mw);
      end

      @(negedge clk);
      #1;
      if (expQ.size() != 0) begin
         miscompares++;
         $display("FAIL drain: %0d predictions left unchecked, want 0", expQ.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Memory-mapped interrupt controller that sits directly upstream of the pipelined CPU's INT input.
- Latches rising edges from NUM_SRC external request lines into a pending register, applies a mask and a fixed priority, and drives a registered INT.
- Software claims and retires interrupts over the CPU data bus (mem_w / Addr_out / Data_out in, Data_in out). There is no nesting: exactly one claim is in service at a time, and it ends with an EOI write before the handler's eret.

Parameters:
- NUM_SRC, 8, number of request sources; legal range 1..32.
- BASE_ADDR, 32'hFFFF_FF00, base of the 256-byte register window. Only bits [31:8] are compared.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- irq_src  input  NUM_SRC  asynchronous request lines. A rising edge requests service.
- addr  input  32  CPU data address (Addr_out).
- wdata  input  32  CPU store data (Data_out).
- mem_w  input  1  CPU store strobe. Sampled at rising clk.
- sel  output  1  combinational; high when addr[31:8]==BASE_ADDR[31:8].
- rdata  output  32  combinational read data for addr. Zero when sel=0 or the offset is unmapped.
- INT  output  1  registered interrupt request to the CPU.

Behaviour:
- Reset (reset=0, asynchronous):
  - synchronisers, pend, mask, claim_id cleared to 0;
  - state=IDLE, INT=0.
- Synchronisation, per source:
  - 3-flop chain s1→s2→s3; rise = s2 & ~s3.
  - A source first sampled high at edge E sets pend at edge E+2. INT rises at edge E+3 if the source is unmasked and state=IDLE.
  - A level held high gives a single request. A new request needs a low period of ≥2 cycles.
- Register map (word offsets; writes act only when sel & mem_w; byte lanes ignored; reads have no side effects):
  - 0x00 PEND: R = pend. W = write-1-to-clear.
  - 0x04 MASK: RW; 1 = enabled. Bits ≥NUM_SRC read 0.
  - 0x08 CLAIM: R = {valid, 26'b0, claim_id[4:0]}, where valid=1 iff state=SERVICE. W (any data) = claim.
  - 0x0C EOI: W (any data) = end of interrupt. Reads 0.
  - 0x10 STATUS: R = {28'b0, INT, pend_masked_any, state[1:0]}. Encoding: IDLE=0, ASSERT=1, SERVICE=2.
  - Other offsets: read 0, writes ignored.
- Priority: lowest index of (pend & mask) wins; this is the combinational winner id.
- State machine:
  - IDLE: if any (pend & mask) → ASSERT, INT←1 (same edge).
  - ASSERT, on CLAIM write:
    - claim_id←winner;
    - pend[winner] cleared;
    - INT←0;
    - → SERVICE.
  - ASSERT, with no CLAIM write and (pend & mask)==0 (masked or cleared by software) → IDLE, INT←0.
  - SERVICE: INT held 0 and new requests only accumulate in pend. EOI write → IDLE; INT may reassert on the following edge.
  - CLAIM write in IDLE or SERVICE and EOI write in IDLE/ASSERT are ignored.
- Simultaneous events on one pend bit in one cycle: a new rise (set) beats a W1C or claim clear, so the new edge is never lost.
- A MASK write and a CLAIM write in the same cycle: the winner uses the old mask.
- Reset asserted mid-SERVICE returns to IDLE immediately and drops all pending requests.

Test Plan:
- Reset, then MASK=0x01, pulse irq_src[0] high for 3 cycles → pend=0x01 at E+2, INT=1 at E+3. Write CLAIM → INT=0, read CLAIM=0x8000_0000. Write EOI → STATUS state=0.
- MASK=0xFF; raise irq_src[5] and irq_src[2] in the same cycle → INT=1; CLAIM read after claim write = 0x8000_0002, PEND=0x20. After EOI, INT=1 again next edge; claim gives id 5.
- MASK=0x00, pulse irq_src[3] → PEND=0x08, INT stays 0. Write MASK=0x08 → INT=1 on the next edge.
- State ASSERT with source 1 pending: write PEND=0x02 (W1C) → INT=0, state IDLE. If irq_src[1] rises such that its set lands in the same cycle as the W1C, PEND bit 1 stays 1 and INT stays high.
- In SERVICE (id 0), pulse irq_src[0] again → INT stays 0, PEND=0x01. Assert reset low mid-cycle → INT, PEND, MASK read 0 immediately.
- Access addr=0x0000_0004 with mem_w=1 → sel=0, MASK unchanged, rdata=0. Read offset 0x20 in-window → 0.
